ram: RTL and testbench
======================

RAM -- requirements
Module: ram

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set data word width in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set address width; depth SHALL be 2**ADDR_W words (16 by default).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset; reset is synchronous and active-high.
REQ-005 Port addr, input, ADDR_W bits, SHALL be the shared read/write word address.
REQ-006 Port data_in, input, DATA_W bits, SHALL be the write data.
REQ-007 Port we, input, 1 bit, SHALL be the write enable, sampled at the rising clk edge.
REQ-008 Port re, input, 1 bit, SHALL be the read enable, sampled at the rising clk edge.
REQ-009 Port data_out, output, DATA_W bits, SHALL be the registered read data.
REQ-010 Port rd_valid, output, 1 bit, SHALL pulse high for one cycle when data_out holds a newly read word.

Function
REQ-011 Write: at a rising edge with we=1 and rst=0, mem[addr] SHALL take data_in; the write is visible to a read at any later edge.
REQ-012 Read: at a rising edge with re=1 and rst=0, data_out SHALL take mem[addr]; latency is one clock from the sampling edge.
REQ-013 data_out SHALL hold its last value in every cycle where re=0.
REQ-014 rd_valid SHALL equal the re value sampled at the previous edge, gated by rst=0.
REQ-015 Simultaneous we=1 and re=1 at the same edge SHALL perform both; data_out SHALL get the old contents of mem[addr] (read-first), unless REQ-021 applies.
REQ-016 Address wraps by width: all 2**ADDR_W locations are valid; no out-of-range case exists.
REQ-017 Uninitialised reads after reset SHALL return 0.
REQ-018 No handshake or backpressure; every enabled access completes in one cycle; back-to-back accesses every cycle SHALL be supported.

Reset
REQ-019 With rst=1 at a rising edge: data_out SHALL become 0, rd_valid SHALL become 0, and every memory word SHALL become 0 in that same edge.
REQ-020 we and re SHALL be ignored while rst=1; an access in the edge rst deasserts is not performed; the first access is at the next edge with rst=0.

Configuration
REQ-021 Macro RAM_WR_FWD_EN: when defined, a simultaneous we=1/re=1 at the same edge SHALL make data_out take data_in (write-first forwarding); when undefined, behaviour SHALL be read-first per REQ-015. All other behaviour is identical.

Structure
REQ-022 Package ram_pkg SHALL hold default DATA_W/ADDR_W constants and the address and data word typedefs.
REQ-023 Storage array and its write port SHALL be one sub-module, ram_array; ram holds the read register, rd_valid, reset clear and forwarding mux.

Verification
REQ-024 Reset then re=1 at addr=4'd7 -> next cycle data_out=8'h00, rd_valid=1.
REQ-025 Write addr=4'd2, data_in=8'hAB, one cycle; idle one cycle; re=1 addr=4'd2 -> data_out=8'hAB one cycle after the read edge, rd_valid pulses once.
REQ-026 Write addr=4'd4, data=8'hCD, then read 4 and read 2 back-to-back -> data_out=8'hCD then 8'hAB on consecutive cycles; data_out holds 8'hAB after re drops.
REQ-027 addr=4'd9 holds 8'h11; we=1, re=1, data_in=8'h22 at the same edge -> data_out=8'h11 without RAM_WR_FWD_EN, 8'h22 with it; a later read returns 8'h22.
REQ-028 Write 8'h5A to addr=4'd15 and 8'hA5 to addr=4'd0, assert rst one cycle, read both -> 8'h00 each; we=1 while rst=1 leaves memory 0.
REQ-029 Continuous writes to all 16 addresses in 16 cycles, then 16 reads -> each data_out matches its write and nothing is lost at addresses 0/15.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and word typedefs for the single-port RAM slice.
package ram_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_DEPTH  = 1 << DEFAULT_ADDR_W;

  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage : ram_pkg

// File: rtl/ram_array.sv
// Storage array with one synchronous write port and an asynchronous read
// of the addressed word. A synchronous reset clears every word.
module ram_array
  import ram_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] rd_word
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear all words on reset, otherwise commit the write at the edge.
  // NOTE: the whole array is reset because reads after reset must return 0;
  // this forces flops instead of a RAM macro, which is acceptable at this depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      // NOTE: non-blocking so the read path below still sees the old word at
      // this edge, which is what gives read-first behaviour for free.
      mem[addr] <= data_in;
    end
  end

  assign rd_word = mem[addr];

endmodule : ram_array

// File: rtl/ram.sv
// Single-port RAM top: registered read data, one-cycle rd_valid pulse and
// synchronous clear. Optional macro RAM_WR_FWD_EN selects write-first
// forwarding on a simultaneous read/write; the default build is read-first.
module ram
  import ram_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

  logic [DATA_W-1:0] mem_word;
  logic [DATA_W-1:0] rd_next;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .rd_word (mem_word)
  );

`ifdef RAM_WR_FWD_EN
  // Write-first: a colliding write is forwarded straight to the read register.
  assign rd_next = we ? data_in : mem_word;
`else
  // Read-first: the read register always captures the pre-write contents.
  assign rd_next = mem_word;
`endif

  // Read register and valid pulse; data_out holds whenever re is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= re;
      if (re) begin
        data_out <= rd_next;
      end
    end
  end

endmodule : ram

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed scenarios followed by random traffic,
// all compared against a behavioural memory model.
module tb_ram;
  import ram_pkg::*;

  localparam int DW = DEFAULT_DATA_W;
  localparam int AW = DEFAULT_ADDR_W;
  localparam int N  = DEFAULT_DEPTH;

`ifdef RAM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  rst, we, re;
  addr_t addr;
  data_t data_in;
  data_t data_out;
  logic  rd_valid;

  // Behavioural model state.
  data_t m_mem [N];
  data_t m_dout;
  logic  m_valid;

  int n_cmp = 0;
  int n_bad = 0;

  ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .we       (we),
    .re       (re),
    .data_out (data_out),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model by the rules of one edge,
  // then compare both outputs against the model.
  task automatic cyc(input logic r, input logic w, input logic rd,
                     input addr_t a, input data_t d, input string tag);
    rst = r; we = w; re = rd; addr = a; data_in = d;
    @(posedge clk);
    if (r) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_dout  = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = rd;
      if (rd) m_dout = (FWD && w) ? d : m_mem[a];
      if (w)  m_mem[a] = d;
    end
    #1;
    check({tag, ".dout"},  data_out, m_dout);
    check({tag, ".valid"}, rd_valid, m_valid);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; data_in = '0;
    foreach (m_mem[i]) m_mem[i] = 'x;
    m_dout = 'x; m_valid = 'x;

    // Reset, then read an untouched location.
    cyc(1, 0, 0, 4'd0, 8'h00, "rst");
    check("rst.dout0", data_out, 8'h00);
    cyc(0, 0, 1, 4'd7, 8'h00, "r24");
    check("r24.const", data_out, 8'h00);
    check("r24.vld", rd_valid, 1'b1);

    // Write, idle, read back; valid pulses once.
    cyc(0, 1, 0, 4'd2, 8'hAB, "r25w");
    cyc(0, 0, 0, 4'd0, 8'h00, "r25i");
    cyc(0, 0, 1, 4'd2, 8'h00, "r25r");
    check("r25.const", data_out, 8'hAB);
    cyc(0, 0, 0, 4'd0, 8'h00, "r25h");
    check("r25.pulse", rd_valid, 1'b0);

    // Back-to-back reads then hold.
    cyc(0, 1, 0, 4'd4, 8'hCD, "r26w");
    cyc(0, 0, 1, 4'd4, 8'h00, "r26a");
    check("r26.cd", data_out, 8'hCD);
    cyc(0, 0, 1, 4'd2, 8'h00, "r26b");
    check("r26.ab", data_out, 8'hAB);
    cyc(0, 0, 0, 4'd0, 8'h00, "r26h");
    check("r26.hold", data_out, 8'hAB);

    // Read/write collision.
    cyc(0, 1, 0, 4'd9, 8'h11, "r27w");
    cyc(0, 1, 1, 4'd9, 8'h22, "r27c");
    check("r27.coll", data_out, FWD ? 8'h22 : 8'h11);
    cyc(0, 0, 1, 4'd9, 8'h00, "r27r");
    check("r27.new", data_out, 8'h22);

    // Reset clears memory; writes during reset are dropped.
    cyc(0, 1, 0, 4'd15, 8'h5A, "r28w");
    cyc(0, 1, 0, 4'd0,  8'hA5, "r28w");
    cyc(1, 1, 1, 4'd15, 8'hFF, "r28rst");
    cyc(0, 0, 1, 4'd15, 8'h00, "r28r");
    check("r28.a15", data_out, 8'h00);
    cyc(0, 0, 1, 4'd0, 8'h00, "r28r");
    check("r28.a0", data_out, 8'h00);

    // Fill every address, then read all back.
    for (int i = 0; i < N; i++) cyc(0, 1, 0, addr_t'(i), data_t'(8'h30 + i*7), "r29w");
    for (int i = 0; i < N; i++) begin
      cyc(0, 0, 1, addr_t'(i), 8'h00, "r29r");
      check("r29.const", data_out, data_t'(8'h30 + i*7));
    end

    // Random traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(39) == 0), $urandom_range(1), $urandom_range(1),
          addr_t'($urandom), data_t'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ram
